// File: rtl/hsk_tx.sv
// hsk_tx: four-phase request/acknowledge transmitter toward another clock domain.
//
// A word is captured on an accepted load and presented on data_out while req_out
// is raised. The receiver's acknowledge (async_ack) is brought into this domain
// through a two-flop synchronizer. The FSM lowers req_out once the synchronized
// acknowledge is high. It returns to idle, pulsing done for one cycle, once the
// synchronized acknowledge has dropped again.
//
// Ports:
//   clk          in   single clock, rising edge
//   n_rst        in   synchronous active-low reset
//   load         in   request to send load_data (ignored while busy)
//   load_data    in   word captured on an accepted load
//   async_ack    in   acknowledge from the receiving domain (asynchronous)
//   req_out      out  registered four-phase request level
//   data_out     out  registered data, stable while req_out=1
//   busy         out  high when a load would be ignored
//   done         out  one-cycle pulse on handshake completion
//   timeout_err  out  sticky timeout flag (0 unless HSK_TIMEOUT_EN)
//
// Optional feature: define HSK_TIMEOUT_EN to add a per-phase timeout counter and
// a terminal ERR state that is left only by reset.

module hsk_tx #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  async_ack,
  output logic                  req_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err
);

`ifdef HSK_TIMEOUT_EN
  typedef enum logic [1:0] {StIdle, StReqHi, StReqLo, StErr} state_e;
`else
  typedef enum logic [1:0] {StIdle, StReqHi, StReqLo} state_e;
`endif

  state_e                state_q, state_d;
  logic                  ack_meta_q, ack_s_q;
  logic                  req_q, req_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  done_q, done_d;

  // Two-flop synchronizer; only the second stage feeds logic.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      ack_meta_q <= 1'b0;
      ack_s_q    <= 1'b0;
    end else begin
      ack_meta_q <= async_ack;
      ack_s_q    <= ack_meta_q;
    end
  end

  // A lingering acknowledge from a previous transfer also blocks new loads.
  assign busy = (state_q != StIdle) || ack_s_q;

`ifdef HSK_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            terr_q, terr_d;
  logic            cnt_expired;

  assign cnt_expired = (cnt_q == CntMax);
`endif

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    done_d  = 1'b0;
`ifdef HSK_TIMEOUT_EN
    terr_d  = terr_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (load && !busy) begin
          state_d = StReqHi;
          req_d   = 1'b1;
          data_d  = load_data;
        end
      end
      StReqHi: begin
        // Acknowledge is checked first so it wins over a coincident timeout.
        if (ack_s_q) begin
          state_d = StReqLo;
          req_d   = 1'b0;
        end
`ifdef HSK_TIMEOUT_EN
        else if (cnt_expired) begin
          state_d = StErr;
          req_d   = 1'b0;
          terr_d  = 1'b1;
        end
`endif
      end
      StReqLo: begin
        if (!ack_s_q) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
`ifdef HSK_TIMEOUT_EN
        else if (cnt_expired) begin
          state_d = StErr;
          req_d   = 1'b0;
          terr_d  = 1'b1;
        end
`endif
      end
`ifdef HSK_TIMEOUT_EN
      StErr: begin
        // Terminal until reset.
        req_d = 1'b0;
      end
`endif
      default: begin
        state_d = StIdle;
        req_d   = 1'b0;
      end
    endcase
  end

`ifdef HSK_TIMEOUT_EN
  // Phase counter: cleared on any state change, counts while waiting for ack_s.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if ((state_q == StReqHi) || (state_q == StReqLo)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      cnt_q  <= '0;
      terr_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      terr_q <= terr_d;
    end
  end

  assign timeout_err = terr_q;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= StIdle;
      req_q   <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  assign req_out  = req_q;
  assign data_out = data_q;
  assign done     = done_q;

endmodule

// File: tb/tb_hsk_tx.sv
// Directed self-checking bench for hsk_tx (DATA_WIDTH=8, TIMEOUT_CYCLES=4).
// Inputs are driven and outputs sampled 1 ns after each rising edge.
// Acknowledge latency seen at req_out/done: two synchronizer edges plus the
// FSM transition edge, so the change appears after the third edge.

module tb_hsk_tx;

  logic       clk;
  logic       n_rst;
  logic       load;
  logic [7:0] load_data;
  logic       async_ack;
  logic       req_out;
  logic [7:0] data_out;
  logic       busy;
  logic       done;
  logic       timeout_err;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int done_base;

  hsk_tx #(
    .DATA_WIDTH    (8),
    .TIMEOUT_CYCLES(4)
  ) u_dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .load       (load),
    .load_data  (load_data),
    .async_ack  (async_ack),
    .req_out    (req_out),
    .data_out   (data_out),
    .busy       (busy),
    .done       (done),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts cycles in which done was high.
  always @(posedge clk) begin
    if (done) done_cnt = done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Completes a handshake already in REQ_HI; leaves the DUT idle in the done cycle.
  task automatic finish_handshake(input string tag, input logic [7:0] exp_data);
    async_ack = 1'b1;
    tick(2);
    check({tag, "_req_hold"}, 32'(req_out), 32'd1);
    tick(1);
    check({tag, "_req_fall"}, 32'(req_out), 32'd0);
    check({tag, "_data_lo"}, 32'(data_out), 32'(exp_data));
    async_ack = 1'b0;
    tick(2);
    check({tag, "_done_early"}, 32'(done), 32'd0);
    tick(1);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
    check({tag, "_data_done"}, 32'(data_out), 32'(exp_data));
  endtask

  initial begin
    n_rst     = 1'b0;
    load      = 1'b1;
    load_data = 8'hA5;
    async_ack = 1'b0;
    #1;

    // Reset with load asserted.
    tick(2);
    check("rst_req", 32'(req_out), 32'd0);
    check("rst_data", 32'(data_out), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_terr", 32'(timeout_err), 32'd0);
    n_rst = 1'b1;
    load  = 1'b0;
    tick(1);

    // Normal transfer with a load attempt while busy.
    done_base = done_cnt;
    load      = 1'b1;
    load_data = 8'h3C;
    tick(1);
    check("nrm_req_rise", 32'(req_out), 32'd1);
    check("nrm_data", 32'(data_out), 32'h3C);
    check("nrm_busy", 32'(busy), 32'd1);
    load_data = 8'hFF;
    tick(1);
    load = 1'b0;
    check("busy_load_data", 32'(data_out), 32'h3C);
    check("busy_load_req", 32'(req_out), 32'd1);
    tick(2);
    finish_handshake("nrm", 8'h3C);
    tick(1);
    check("nrm_done_pulse", 32'(done), 32'd0);
    check("nrm_done_count", 32'(done_cnt - done_base), 32'd1);

    // Stale acknowledge blocks a load.
    async_ack = 1'b1;
    tick(2);
    check("stale_busy", 32'(busy), 32'd1);
    load      = 1'b1;
    load_data = 8'h11;
    tick(1);
    load = 1'b0;
    check("stale_req", 32'(req_out), 32'd0);
    check("stale_data", 32'(data_out), 32'h3C);
    async_ack = 1'b0;
    tick(1);
    check("stale_busy_hold", 32'(busy), 32'd1);
    tick(1);
    check("stale_busy_clr", 32'(busy), 32'd0);
    check("stale_req_clr", 32'(req_out), 32'd0);

    // Back-to-back transfers.
    load      = 1'b1;
    load_data = 8'h01;
    tick(1);
    load = 1'b0;
    check("b2b_data1", 32'(data_out), 32'h01);
    finish_handshake("b2b1", 8'h01);
    load      = 1'b1;
    load_data = 8'h02;
    tick(1);
    load = 1'b0;
    check("b2b_req2", 32'(req_out), 32'd1);
    check("b2b_data2", 32'(data_out), 32'h02);
    check("b2b_done_clr", 32'(done), 32'd0);
    finish_handshake("b2b2", 8'h02);
    tick(1);

    // Reset mid-handshake aborts without done.
    load      = 1'b1;
    load_data = 8'h55;
    tick(1);
    load = 1'b0;
    check("abort_req", 32'(req_out), 32'd1);
    done_base = done_cnt;
    n_rst     = 1'b0;
    tick(1);
    n_rst = 1'b1;
    check("abort_req_clr", 32'(req_out), 32'd0);
    check("abort_data_clr", 32'(data_out), 32'h00);
    tick(4);
    check("abort_no_done", 32'(done_cnt - done_base), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);

    // Acknowledge never arrives.
    load      = 1'b1;
    load_data = 8'h77;
    tick(1);
    load = 1'b0;
`ifdef HSK_TIMEOUT_EN
    tick(4);
    check("to_req_wait", 32'(req_out), 32'd1);
    check("to_terr_wait", 32'(timeout_err), 32'd0);
    tick(1);
    check("to_req", 32'(req_out), 32'd0);
    check("to_terr", 32'(timeout_err), 32'd1);
    check("to_busy", 32'(busy), 32'd1);
    async_ack = 1'b1;
    tick(4);
    async_ack = 1'b0;
    tick(4);
    check("to_terr_sticky", 32'(timeout_err), 32'd1);
    check("to_req_sticky", 32'(req_out), 32'd0);
    n_rst = 1'b0;
    tick(1);
    n_rst = 1'b1;
    check("to_terr_rst", 32'(timeout_err), 32'd0);
    check("to_busy_rst", 32'(busy), 32'd0);
`else
    tick(20);
    check("wait_req", 32'(req_out), 32'd1);
    check("wait_terr", 32'(timeout_err), 32'd0);
    check("wait_data", 32'(data_out), 32'h77);
    finish_handshake("wait", 8'h77);
    tick(1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
